// File: rtl/instruction_fetch_unit_pkg.sv
// Shared opcode, field-slice and state definitions for the instruction fetch unit.
// The NOP-delay state is only used when FETCH_NOP_DELAY_EN is defined.
package instruction_fetch_unit_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LED  = 4'h1;
   localparam logic [3:0] OP_BLE  = 4'h2;
   localparam logic [3:0] OP_STO  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_SMUL = 4'h7;

   localparam int OPCODE_MSB = 27;
   localparam int OPCODE_LSB = 24;
   localparam int DEST_MSB   = 23;
   localparam int DEST_LSB   = 16;
   localparam int IMM_W      = 24;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_DELAY = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_nop_delay_counter.sv
// Down-counter that times a NOP-with-immediate delay; exists only when
// FETCH_NOP_DELAY_EN is defined.
`ifdef FETCH_NOP_DELAY_EN
module nop_delay_counter
   import instruction_fetch_unit_pkg::*;
#(
   parameter int W = IMM_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // A clear (branch redirect) wins over a simultaneous load or decrement.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`endif

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, resolves JMP locally, accepts branch redirects.
// FETCH_NOP_DELAY_EN turns a NOP with nonzero immediate into a multi-cycle delay.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                INSN_W   = 28,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_NOP_DELAY_EN
   ,
   parameter int                DELAY_W  = 24
`endif
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic [ADDR_W-1:0] oAddress,
   input  logic [INSN_W-1:0] iInstruction,
   input  logic              iStall,
   input  logic              iRedirect,
   input  logic [ADDR_W-1:0] iRedirectTarget,
   output logic [INSN_W-1:0] oInstruction,
   output logic [ADDR_W-1:0] oPC,
   output logic              oValid,
   output logic              oDelayBusy
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pc_out;
   logic [INSN_W-1:0] r_insn;
   logic              r_valid;

   logic [3:0]        w_opcode;
   logic              w_is_jmp;
   logic [ADDR_W-1:0] w_jmp_target;
   logic              w_advance;

   assign w_opcode     = iInstruction[OPCODE_MSB:OPCODE_LSB];
   assign w_is_jmp     = (w_opcode == OP_JMP);
   assign w_jmp_target = ADDR_W'(iInstruction[DEST_MSB:DEST_LSB]);
   assign w_advance    = !iRedirect && !iStall;

`ifdef FETCH_NOP_DELAY_EN
   fetch_state_t       r_state;
   logic               r_delay_busy;
   logic [DELAY_W-1:0] w_imm;
   logic               w_is_delay_nop;
   logic               w_cnt_load;
   logic               w_cnt_dec;
   logic               w_cnt_zero;

   assign w_imm          = iInstruction[DELAY_W-1:0];
   assign w_is_delay_nop = (w_opcode == OP_NOP) && (w_imm != '0);
   assign w_cnt_load     = w_advance && (r_state == ST_FETCH) && w_is_delay_nop;
   assign w_cnt_dec      = w_advance && (r_state == ST_DELAY);

   // Loaded with N-1 so that the DELAY state lasts exactly N cycles.
   nop_delay_counter #(
      .W (DELAY_W)
   ) u_delay (
      .i_clk   (Clock),
      .i_rst   (Reset),
      .i_clear (iRedirect),
      .i_load  (w_cnt_load),
      .i_value (w_imm - 1'b1),
      .i_dec   (w_cnt_dec),
      .o_zero  (w_cnt_zero)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pc         <= RESET_PC;
         r_pc_out     <= '0;
         r_insn       <= '0;
         r_valid      <= 1'b0;
         r_delay_busy <= 1'b0;
         r_state      <= ST_FETCH;
      end else if (iRedirect) begin
         // The instruction fetched behind the taken branch is flushed.
         r_pc         <= iRedirectTarget;
         r_valid      <= 1'b0;
         r_delay_busy <= 1'b0;
         r_state      <= ST_FETCH;
      end else if (!iStall) begin
         case (r_state)
            ST_DELAY: begin
               r_valid <= 1'b0;
               if (w_cnt_zero) begin
                  r_state      <= ST_FETCH;
                  r_delay_busy <= 1'b0;
               end
            end
            default: begin
               if (w_is_jmp) begin
                  r_pc    <= w_jmp_target;
                  r_valid <= 1'b0;
               end else begin
                  r_insn   <= iInstruction;
                  r_pc_out <= r_pc;
                  r_valid  <= 1'b1;
                  r_pc     <= r_pc + 1'b1;
                  if (w_is_delay_nop) begin
                     r_state      <= ST_DELAY;
                     r_delay_busy <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign oDelayBusy = r_delay_busy;
`else
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pc     <= RESET_PC;
         r_pc_out <= '0;
         r_insn   <= '0;
         r_valid  <= 1'b0;
      end else if (iRedirect) begin
         r_pc    <= iRedirectTarget;
         r_valid <= 1'b0;
      end else if (!iStall) begin
         if (w_is_jmp) begin
            r_pc    <= w_jmp_target;
            r_valid <= 1'b0;
         end else begin
            r_insn   <= iInstruction;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 1'b1;
         end
      end
   end

   assign oDelayBusy = 1'b0;
`endif

   assign oAddress     = r_pc;
   assign oInstruction = r_insn;
   assign oPC          = r_pc_out;
   assign oValid       = r_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle table plus hand sequences for
// NOP delays, redirect-during-delay and asynchronous reset.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] address;
   logic [27:0] insn_in;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [15:0] tgt = 16'h0;
   logic [27:0] insn_out;
   logic [15:0] pc_out;
   logic        valid;
   logic        busy;

   logic [27:0] rom [0:65535];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign insn_in = rom[address];

   instruction_fetch_unit dut (
      .Clock           (clk),
      .Reset           (rst),
      .oAddress        (address),
      .iInstruction    (insn_in),
      .iStall          (stall),
      .iRedirect       (redir),
      .iRedirectTarget (tgt),
      .oInstruction    (insn_out),
      .oPC             (pc_out),
      .oValid          (valid),
      .oDelayBusy      (busy)
   );

   typedef struct {
      logic        stall;
      logic        redir;
      logic [15:0] tgt;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_pc;
      logic [27:0] e_insn;
   } vec_t;

   vec_t vecs [18];

`ifdef FETCH_NOP_DELAY_EN
   localparam bit DELAY_ON = 1'b1;
`else
   localparam bit DELAY_ON = 1'b0;
`endif

   function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
      return {op, d, s1, s0};
   endfunction

   function automatic logic [27:0] mknop(input int n);
      return {OP_NOP, 24'(n)};
   endfunction

   function automatic vec_t mkv(input logic st, input logic rd, input logic [15:0] tg,
                                input logic [15:0] a, input logic v, input logic [15:0] p,
                                input logic [27:0] ins);
      vec_t r;
      r.stall = st; r.redir = rd; r.tgt = tg;
      r.e_addr = a; r.e_valid = v; r.e_pc = p; r.e_insn = ins;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 16'h0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Issue a NOP of n at address 0, then count bubbles until address 1 issues.
   task automatic nop_case(input int n);
      int zeros;
      int busys;
      bit found;
      rom[0] = mknop(n);
      do_reset();
      step();
      chk("nop_issue_valid", 32'(valid), 32'd1);
      chk("nop_issue_insn", 32'(insn_out), 32'(mknop(n)));
      zeros = 0;
      busys = busy ? 1 : 0;
      found = 1'b0;
      for (int i = 0; i < n + 20; i++) begin
         step();
         if (valid) begin
            found = 1'b1;
            break;
         end
         zeros++;
         if (busy) busys++;
      end
      chk("nop_next_found", 32'(found), 32'd1);
      chk("nop_gap_cycles", 32'(zeros), DELAY_ON ? 32'(n) : 32'd0);
      chk("nop_busy_cycles", 32'(busys), DELAY_ON ? 32'(n) : 32'd0);
      chk("nop_next_pc", 32'(pc_out), 32'd1);
      $display("nop n=%0d gap=%0d busy=%0d next_pc=%h", n, zeros, busys, pc_out);
   endtask

   logic [27:0] r0, r1, r2, r3, r4, r5, r6, r7, r14, rff;

   initial begin
      for (int a = 0; a < 65536; a++) rom[a] = 28'h0;
      r0  = mk(OP_STO, 8'h01, 8'h02, 8'h03);
      r1  = mk(OP_STO, 8'h04, 8'h05, 8'h06);
      r2  = mk(OP_ADD, 8'h07, 8'h08, 8'h09);
      r3  = mk(OP_LED, 8'h00, 8'h0A, 8'h00);
      r4  = mk(OP_JMP, 8'd14, 8'h00, 8'h00);
      r5  = mk(OP_ADD, 8'h11, 8'h12, 8'h13);
      r6  = mknop(0);
      r7  = 28'hF123456;
      r14 = mk(OP_JMP, 8'd2, 8'h00, 8'h00);
      rff = mk(OP_STO, 8'hAA, 8'hBB, 8'hCC);
      rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3; rom[4] = r4;
      rom[5] = r5; rom[6] = r6; rom[7] = r7; rom[14] = r14; rom[16'hFFFF] = rff;

      //                 stall redir tgt        addr       v  pc        insn
      vecs[0]  = mkv(0, 0, 16'h0,    16'd1,    1, 16'd0,    r0);
      vecs[1]  = mkv(0, 0, 16'h0,    16'd2,    1, 16'd1,    r1);
      vecs[2]  = mkv(0, 0, 16'h0,    16'd3,    1, 16'd2,    r2);
      vecs[3]  = mkv(0, 0, 16'h0,    16'd4,    1, 16'd3,    r3);
      vecs[4]  = mkv(0, 0, 16'h0,    16'd14,   0, 16'd3,    r3);
      vecs[5]  = mkv(0, 0, 16'h0,    16'd2,    0, 16'd3,    r3);
      vecs[6]  = mkv(0, 0, 16'h0,    16'd3,    1, 16'd2,    r2);
      vecs[7]  = mkv(1, 0, 16'h0,    16'd3,    1, 16'd2,    r2);
      vecs[8]  = mkv(1, 0, 16'h0,    16'd3,    1, 16'd2,    r2);
      vecs[9]  = mkv(1, 0, 16'h0,    16'd3,    1, 16'd2,    r2);
      vecs[10] = mkv(0, 0, 16'h0,    16'd4,    1, 16'd3,    r3);
      vecs[11] = mkv(1, 1, 16'd5,    16'd5,    0, 16'd3,    r3);
      vecs[12] = mkv(0, 0, 16'h0,    16'd6,    1, 16'd5,    r5);
      vecs[13] = mkv(0, 0, 16'h0,    16'd7,    1, 16'd6,    r6);
      vecs[14] = mkv(0, 0, 16'h0,    16'd8,    1, 16'd7,    r7);
      vecs[15] = mkv(0, 1, 16'hFFFF, 16'hFFFF, 0, 16'd7,    r7);
      vecs[16] = mkv(0, 0, 16'h0,    16'd0,    1, 16'hFFFF, rff);
      vecs[17] = mkv(0, 0, 16'h0,    16'd1,    1, 16'd0,    r0);

      do_reset();
      rst = 1'b1;
      #1;
      chk("reset_addr", 32'(address), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_pc", 32'(pc_out), 32'd0);
      chk("reset_insn", 32'(insn_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         stall = vecs[i].stall;
         redir = vecs[i].redir;
         tgt   = vecs[i].tgt;
         step();
         $display("vec %0d addr=%h valid=%b pc=%h insn=%h", i, address, valid, pc_out, insn_out);
         chk($sformatf("vec%0d_addr", i), 32'(address), 32'(vecs[i].e_addr));
         chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vecs[i].e_pc));
         chk($sformatf("vec%0d_insn", i), 32'(insn_out), 32'(vecs[i].e_insn));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      end
      stall = 1'b0; redir = 1'b0;

      nop_case(4000);
      nop_case(1);

      // Redirect while stalled during an active delay.
      rom[0] = mknop(4000);
      do_reset();
      step();
      step();
      step();
      chk("redir_pre_busy", 32'(busy), DELAY_ON ? 32'd1 : 32'd0);
      stall = 1'b1; redir = 1'b1; tgt = 16'd5;
      step();
      $display("redirect addr=%h valid=%b busy=%b", address, valid, busy);
      chk("redir_addr", 32'(address), 32'd5);
      chk("redir_valid", 32'(valid), 32'd0);
      chk("redir_busy", 32'(busy), 32'd0);
      stall = 1'b0; redir = 1'b0;
      step();
      chk("redir_next_valid", 32'(valid), 32'd1);
      chk("redir_next_pc", 32'(pc_out), 32'd5);
      chk("redir_next_insn", 32'(insn_out), 32'(r5));

      // Asynchronous reset in the middle of a delay issued from 16'hFFFF.
      rom[0] = r0;
      rom[16'hFFFF] = mknop(10);
      do_reset();
      redir = 1'b1; tgt = 16'hFFFF;
      step();
      redir = 1'b0;
      step();
      chk("wrap_issue_pc", 32'(pc_out), 32'hFFFF);
      chk("wrap_issue_addr", 32'(address), 32'd0);
      chk("wrap_issue_busy", 32'(busy), DELAY_ON ? 32'd1 : 32'd0);
      step();
      #3;
      rst = 1'b1;
      #1;
      $display("async reset addr=%h valid=%b pc=%h insn=%h busy=%b", address, valid, pc_out, insn_out, busy);
      chk("areset_addr", 32'(address), 32'd0);
      chk("areset_valid", 32'(valid), 32'd0);
      chk("areset_pc", 32'(pc_out), 32'd0);
      chk("areset_insn", 32'(insn_out), 32'd0);
      chk("areset_busy", 32'(busy), 32'd0);
      #1;
      rst = 1'b0;
      step();
      chk("areset_resume_valid", 32'(valid), 32'd1);
      chk("areset_resume_pc", 32'(pc_out), 32'd0);
      chk("areset_resume_insn", 32'(insn_out), 32'(r0));
      step();
      chk("areset_resume_pc1", 32'(pc_out), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction-ROM interface: owns the program counter, drives the ROM address, captures the 28-bit instruction returned combinationally, and hands it to the execute stage with a valid/stall handshake.
- Resolves JMP locally.
- Executes NOP-with-immediate as a cycle-accurate delay.
- Accepts branch redirects (BLE taken) from execute.
- Sits between the program ROM and the MiniAlu execute/register-file stage.

Parameters:
ADDR_W, 16, program-counter and ROM address width
INSN_W, 28, instruction width; opcode [27:24], dest/target [23:16], src1 [15:8], src0 [7:0]
DELAY_W, 24, NOP delay-counter width (NOP immediate is [23:0])
RESET_PC, 0, PC value loaded on reset

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
oAddress  output  ADDR_W  ROM address, equals current PC (combinational from PC register)
iInstruction  input  INSN_W  ROM data for oAddress, valid same cycle
iStall  input  1  execute cannot accept; hold all outputs and PC
iRedirect  input  1  execute resolved a taken branch this cycle
iRedirectTarget  input  ADDR_W  branch target; valid with iRedirect
oInstruction  output  INSN_W  registered instruction to execute
oPC  output  ADDR_W  address oInstruction was fetched from
oValid  output  1  oInstruction is live and must be executed
oDelayBusy  output  1  NOP delay in progress

Behaviour:
- Reset (async, any state): PC=RESET_PC, oInstruction=0 (NOP, imm 0), oPC=0, oValid=0, oDelayBusy=0, delay counter=0, state=FETCH.
- States: FETCH, DELAY.
- Priority per edge: Reset > iRedirect > iStall > local decode.
- iRedirect (any state): PC<=iRedirectTarget; oValid<=0 (the in-flight instruction fetched after the branch is flushed); delay aborted, counter<=0; state<=FETCH. iRedirect is honoured even if iStall=1.
- iStall=1, no redirect: PC, oInstruction, oPC, oValid and counter all frozen.
- FETCH, no stall, by opcode of iInstruction:
  - Any opcode other than JMP and nonzero-immediate NOP: oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
  - JMP: PC<={8'b0, iInstruction[23:16]}; oValid<=0. JMP is not forwarded, so it costs one bubble.
  - NOP with imm=0: forwarded as an ordinary instruction.
  - NOP with imm=N>0: forwarded (oValid<=1, oPC<=PC); counter<=N-1; PC<=PC+1; state<=DELAY; oDelayBusy<=1. If N=1, the counter is 0 and DELAY lasts one cycle.
- DELAY, no stall: oValid<=0. If counter=0: state<=FETCH, oDelayBusy<=0. Else counter<=counter-1.
- A NOP of N therefore occupies exactly N+1 cycles from its issue to the next oValid.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 0 silently.
- Fetch latency: address presented in cycle t, instruction on oInstruction/oValid after the edge ending t (1 cycle).
- ROM default/unmapped words are forwarded unchanged; illegal opcodes are not trapped here.

Optional Feature:
- Macro: FETCH_NOP_DELAY_EN.
- Defined: NOP-immediate delay behaves as above; DELAY state and counter exist.
- Undefined: every NOP is forwarded as a single-cycle instruction; the DELAY state, counter and related logic are not synthesised; oDelayBusy is tied to 0.

Decomposition:
- Shared definitions package holds:
  - opcode constants (NOP, LED, BLE, STO, ADD, JMP, …)
  - field-slice constants: OPCODE_MSB/LSB, DEST_MSB/LSB, IMM width
  - the state encoding for FETCH/DELAY
- One sub-module is natural: nop_delay_counter. It holds the load/decrement/zero-flag logic and is wrapped by the FETCH_NOP_DELAY_EN guard.

Test Plan:
- Reset release, ROM words 0..3 = STO, STO, ADD, LED (stall low) -> oAddress 0,1,2,3 on successive cycles; oValid=1 from cycle 1; oPC=0,1,2,3.
- JMP to 8'd2 at address 14 -> oAddress goes 14 then 2; one cycle of oValid=0; JMP never appears on oInstruction.
- NOP imm 24'd4000 at address 0 -> NOP issued with oValid=1, then exactly 4000 cycles of oValid=0 with oDelayBusy=1, then address 1 issued. With the macro undefined: address 1 issued on the next cycle.
- iRedirect=1, target 16'd5, asserted while iStall=1 and during an active delay -> next oAddress=5, oValid=0 that cycle, oDelayBusy=0, delay abandoned.
- iStall held for 3 cycles mid-stream -> oInstruction, oPC, oAddress unchanged for 3 cycles; no instruction lost or duplicated afterwards.
- Reset asserted asynchronously mid-DELAY, PC=16'hFFFF -> outputs clear immediately without a clock edge; after release, fetch resumes at 0. Separately, a non-branch at 16'hFFFF -> next oAddress=0.
